// File: rtl/lvds_tx_scheduler_if.sv
// Purpose: bundles the strobe, link-enable, two requester streams and serializer outputs of the scheduler.
// Latency: none; this is wiring only.
// Backpressure: the readies live here; the scheduler drives them and the upstream holds words until accepted.
interface lvds_tx_scheduler_if;
    logic        slot_strobe;
    logic        tx_en;
    logic [31:0] smp_data;
    logic        smp_valid;
    logic        smp_ready;
    logic [31:0] ctl_data;
    logic        ctl_valid;
    logic        ctl_ready;
    logic [31:0] tx_data;
    logic        tx_active;
    logic [15:0] underrun_cnt;

    // Scheduler side
    modport slave (
        input  slot_strobe, tx_en, smp_data, smp_valid, ctl_data, ctl_valid,
        output smp_ready, ctl_ready, tx_data, tx_active, underrun_cnt
    );

    // Serializer/requester side
    modport master (
        output slot_strobe, tx_en, smp_data, smp_valid, ctl_data, ctl_valid,
        input  smp_ready, ctl_ready, tx_data, tx_active, underrun_cnt
    );
endinterface

// File: rtl/lvds_tx_scheduler.sv
// Purpose: picks one 32-bit word per serializer slot from sync/preamble, control, sample or idle fill.
// Latency: a word accepted on strobe N sits in tx_data and is loaded by the serializer on strobe N+1.
// Backpressure: readies pulse only on a strobe for the granted source; ungranted words wait upstream.
module lvds_tx_scheduler #(
    parameter logic [31:0] SYNC_WORD     = 32'hA5A5_5A5A,
    parameter logic [31:0] IDLE_WORD     = 32'h0000_0000,
    parameter int          PREAMBLE_LEN  = 4,
    parameter int          SYNC_PERIOD   = 64,
    parameter int          CTRL_MAX_WAIT = 4
) (
    input  logic             clk64mhz,
    input  logic             reset,
    lvds_tx_scheduler_if.slave bus
);
    typedef enum logic [1:0] {ST_OFF, ST_PREAMBLE, ST_RUN, ST_DRAIN} state_t;

    localparam logic [15:0] SYNC_LAST = 16'(SYNC_PERIOD - 1);
    localparam logic [3:0]  CTL_MAX   = 4'(CTRL_MAX_WAIT);
    localparam logic [8:0]  PRE_LEN   = 9'(PREAMBLE_LEN);

    state_t      state_q, state_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic        tx_active_q, tx_active_d;
    logic [15:0] underrun_q, underrun_d;
    logic [7:0]  pre_cnt_q, pre_cnt_d;
    logic [15:0] sync_cnt_q, sync_cnt_d;
    logic [3:0]  ctl_wait_q, ctl_wait_d;
    logic        smp_rdy, ctl_rdy;
    logic        sync_due, ctl_pick;

    assign sync_due = (sync_cnt_q == SYNC_LAST);
    // Control goes first once it has waited long enough, or whenever samples have nothing to offer.
    assign ctl_pick = bus.ctl_valid & ((ctl_wait_q >= CTL_MAX) | ~bus.smp_valid);

    // Slot decision: everything advances only on the serializer load strobe.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_active_d = tx_active_q;
        underrun_d  = underrun_q;
        pre_cnt_d   = pre_cnt_q;
        sync_cnt_d  = sync_cnt_q;
        ctl_wait_d  = ctl_wait_q;
        smp_rdy     = 1'b0;
        ctl_rdy     = 1'b0;
        if (bus.slot_strobe) begin
            case (state_q)
                ST_OFF: begin
                    if (bus.tx_en) begin
                        // The entry strobe already sends the first preamble word.
                        state_d     = (PREAMBLE_LEN == 1) ? ST_RUN : ST_PREAMBLE;
                        tx_active_d = 1'b1;
                        tx_data_d   = SYNC_WORD;
                        pre_cnt_d   = 8'd0;
                        sync_cnt_d  = 16'd0;
                    end else begin
                        tx_active_d = 1'b0;
                        tx_data_d   = IDLE_WORD;
                    end
                end
                ST_PREAMBLE: begin
                    if (!bus.tx_en) begin
                        state_d   = ST_DRAIN;
                        tx_data_d = IDLE_WORD;
                    end else begin
                        tx_data_d = SYNC_WORD;
                        pre_cnt_d = pre_cnt_q + 8'd1;
                        // pre_cnt_q+1 words already sent, this strobe adds one more.
                        if ({1'b0, pre_cnt_q} + 9'd2 >= PRE_LEN) begin
                            state_d    = ST_RUN;
                            sync_cnt_d = 16'd0;
                        end
                    end
                end
                ST_RUN: begin
                    if (!bus.tx_en) begin
                        state_d   = ST_DRAIN;
                        tx_data_d = IDLE_WORD;
                    end else if (sync_due) begin
                        tx_data_d  = SYNC_WORD;
                        sync_cnt_d = 16'd0;
                        if (bus.ctl_valid && ctl_wait_q < CTL_MAX) ctl_wait_d = ctl_wait_q + 4'd1;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 16'd1;
                        if (ctl_pick) begin
                            ctl_rdy    = 1'b1;
                            tx_data_d  = bus.ctl_data;
                            ctl_wait_d = 4'd0;
                        end else begin
                            if (bus.smp_valid) begin
                                smp_rdy   = 1'b1;
                                tx_data_d = bus.smp_data;
                            end else begin
                                tx_data_d = IDLE_WORD;
                                if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
                            end
                            if (bus.ctl_valid && ctl_wait_q < CTL_MAX) ctl_wait_d = ctl_wait_q + 4'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_d     = ST_OFF;
                    tx_active_d = 1'b0;
                    tx_data_d   = IDLE_WORD;
                    ctl_wait_d  = 4'd0;
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // State and output registers; reset puts the link in a quiet, idle state immediately.
    always_ff @(posedge clk64mhz or posedge reset) begin
        if (reset) begin
            state_q     <= ST_OFF;
            tx_data_q   <= IDLE_WORD;
            tx_active_q <= 1'b0;
            underrun_q  <= 16'd0;
            pre_cnt_q   <= 8'd0;
            sync_cnt_q  <= 16'd0;
            ctl_wait_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_active_q <= tx_active_d;
            underrun_q  <= underrun_d;
            pre_cnt_q   <= pre_cnt_d;
            sync_cnt_q  <= sync_cnt_d;
            ctl_wait_q  <= ctl_wait_d;
        end
    end

    assign bus.smp_ready    = smp_rdy;
    assign bus.ctl_ready    = ctl_rdy;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_active    = tx_active_q;
    assign bus.underrun_cnt = underrun_q;
endmodule
